// File: rtl/input_buffer.sv
// Byte-to-word assembler with a two-deep output queue (output reg + hold reg).
// Optional idle-timeout discard of partial words is compiled in with INBUF_TIMEOUT_EN.
module input_buffer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iValid,
    input  logic [7:0]  iData,
    input  logic        iReady,
    input  logic        iClr,
    output logic [31:0] oData,
    output logic        oValid,
    output logic        oOvf
`ifdef INBUF_TIMEOUT_EN
    ,
    output logic        oTmo
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occState_e;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : gBadTimeout
        $error("input_buffer: TIMEOUT must be in 1..255");
    end

    logic [1:0]  cnt;
    logic [1:0]  byteIdx;
    logic [23:0] partial;
    logic [31:0] newWord;
    logic        tmoEvt;
    logic        complete;
    logic        xfer;

    occState_e   state, stateNext;
    logic [31:0] outReg, outNext;
    logic [31:0] holdReg, holdNext;
    logic        ovfSet;

    // A timeout on the same edge as a byte restarts the word at byte 0.
    assign byteIdx  = tmoEvt ? 2'd0 : cnt;
    assign complete = iValid && (byteIdx == 2'd3);
    assign newWord  = {partial, iData};
    assign xfer     = iReady && (state != EMPTY);

    assign oData  = outReg;
    assign oValid = (state != EMPTY);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 2'd0;
            partial <= 24'd0;
        end else if (iValid) begin
            cnt     <= byteIdx + 2'd1;
            partial <= {partial[15:0], iData};
        end else if (tmoEvt) begin
            cnt     <= 2'd0;
        end
    end

`ifdef INBUF_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    logic [7:0] idleCnt;

    assign tmoEvt = (cnt != 2'd0) && (idleCnt == TMO_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idleCnt <= 8'd0;
            oTmo    <= 1'b0;
        end else begin
            if (iValid || tmoEvt)
                idleCnt <= 8'd0;
            else if (cnt != 2'd0)
                idleCnt <= idleCnt + 8'd1;

            if (tmoEvt)
                oTmo <= 1'b1;
            else if (iClr)
                oTmo <= 1'b0;
        end
    end
`else
    assign tmoEvt = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        outNext   = outReg;
        holdNext  = holdReg;
        ovfSet    = 1'b0;
        unique case (state)
            EMPTY: begin
                if (complete) begin
                    outNext   = newWord;
                    stateNext = ONE;
                end
            end
            ONE: begin
                if (xfer && complete) begin
                    outNext = newWord;
                end else if (xfer) begin
                    stateNext = EMPTY;
                end else if (complete) begin
                    holdNext  = newWord;
                    stateNext = TWO;
                end
            end
            TWO: begin
                if (xfer) begin
                    outNext = holdReg;
                    if (complete)
                        holdNext = newWord;
                    else
                        stateNext = ONE;
                end else if (complete) begin
                    ovfSet = 1'b1;
                end
            end
            default: stateNext = EMPTY;
        endcase
    end

    // NOTE: both word registers are reset; they are plain registers, not a
    // RAM, and oData must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            outReg  <= 32'd0;
            holdReg <= 32'd0;
            oOvf    <= 1'b0;
        end else begin
            state   <= stateNext;
            outReg  <= outNext;
            holdReg <= holdNext;
            if (ovfSet)
                oOvf <= 1'b1;
            else if (iClr)
                oOvf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer: directed scenarios plus random traffic
// against a queue-based reference model. Timeout scenarios run with INBUF_TIMEOUT_EN.
module tb_input_buffer;

`ifdef INBUF_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iValid = 1'b0;
    logic [7:0]  iData = 8'd0;
    logic        iReady = 1'b0;
    logic        iClr = 1'b0;
    logic [31:0] oData;
    logic        oValid;
    logic        oOvf;
`ifdef INBUF_TIMEOUT_EN
    logic        oTmo;
`endif

    always #5 clk = ~clk;

    input_buffer #(.TIMEOUT(TMO)) dut (
        .clk    (clk),
        .rst    (rst),
        .iValid (iValid),
        .iData  (iData),
        .iReady (iReady),
        .iClr   (iClr),
        .oData  (oData),
        .oValid (oValid),
        .oOvf   (oOvf)
`ifdef INBUF_TIMEOUT_EN
        ,
        .oTmo   (oTmo)
`endif
    );

    int testCnt = 0;
    int failCnt = 0;

    // Reference model: bytes of the word in progress, words waiting for the consumer.
    logic [7:0]  mBytes[$];
    logic [31:0] mStore[$];
    int          mIdle;
    bit          mOvf;
    bit          mTmo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBytes.delete();
        mStore.delete();
        mIdle = 0;
        mOvf  = 0;
        mTmo  = 0;
    endtask

    task automatic modelEdge(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        bit          xfer, full, complete, ovfSet, tmoSet;
        logic [31:0] w;
        xfer     = rdy && (mStore.size() != 0);
        full     = (mStore.size() == 2);
        complete = 0;
        ovfSet   = 0;
        tmoSet   = 0;
        w        = 32'd0;
`ifdef INBUF_TIMEOUT_EN
        if (mBytes.size() != 0 && mIdle == TMO) begin
            mBytes.delete();
            tmoSet = 1;
            mIdle  = 0;
        end else if (!v && mBytes.size() != 0) begin
            mIdle++;
        end
        if (v) mIdle = 0;
`endif
        if (v) begin
            mBytes.push_back(d);
            if (mBytes.size() == 4) begin
                w = {mBytes[0], mBytes[1], mBytes[2], mBytes[3]};
                mBytes.delete();
                complete = 1;
            end
        end
        if (xfer) mStore.delete(0);
        if (complete) begin
            if (full && !xfer) ovfSet = 1;
            else mStore.push_back(w);
        end
        mOvf = ovfSet ? 1'b1 : (clr ? 1'b0 : mOvf);
        mTmo = tmoSet ? 1'b1 : (clr ? 1'b0 : mTmo);
    endtask

    task automatic checkOut(input string tag);
        check({tag, "_valid"}, {31'd0, oValid}, {31'd0, mStore.size() != 0});
        if (mStore.size() != 0)
            check({tag, "_data"}, oData, mStore[0]);
        check({tag, "_ovf"}, {31'd0, oOvf}, {31'd0, mOvf});
`ifdef INBUF_TIMEOUT_EN
        check({tag, "_tmo"}, {31'd0, oTmo}, {31'd0, mTmo});
`endif
    endtask

    // Called at a falling edge; drives inputs, advances one rising edge, checks, returns at the next falling edge.
    task automatic step(input string tag, input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        iValid = v;
        iData  = d;
        iReady = rdy;
        iClr   = clr;
        modelEdge(v, d, rdy, clr);
        @(posedge clk);
        #1;
        checkOut(tag);
        @(negedge clk);
    endtask

    task automatic sendWord(input string tag, input logic [31:0] w, input bit rdy,
                            input bit lastRdy, input bit lastClr);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[31 - 8*i -: 8];
            if (i == 3) step(tag, 1'b1, b, lastRdy, lastClr);
            else        step(tag, 1'b1, b, rdy, 1'b0);
        end
    endtask

    task automatic idle(input string tag, input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    // Asserts reset between clock edges and checks the asynchronous clear before any edge.
    task automatic resetPulse(input string tag);
        #2;
        rst    = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        iClr   = 1'b0;
        #1;
        check({tag, "_valid"}, {31'd0, oValid}, 32'd0);
        check({tag, "_data"}, oData, 32'd0);
        check({tag, "_ovf"}, {31'd0, oOvf}, 32'd0);
`ifdef INBUF_TIMEOUT_EN
        check({tag, "_tmo"}, {31'd0, oTmo}, 32'd0);
`endif
        modelReset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        modelReset();
        @(negedge clk);
        resetPulse("reset");

        // Single word, consumer always ready.
        sendWord("basic", 32'h12345678, 1'b1, 1'b1, 1'b0);
        check("basic_word", oData, 32'h12345678);
        idle("basic_drain", 1, 1'b1);
        check("basic_empty", {31'd0, oValid}, 32'd0);

        // Two words held, third dropped, then drained in order.
        sendWord("ovf", 32'hAABBCCDD, 1'b0, 1'b0, 1'b0);
        sendWord("ovf", 32'h01020304, 1'b0, 1'b0, 1'b0);
        sendWord("ovf", 32'h0A0B0C0D, 1'b0, 1'b0, 1'b0);
        check("ovf_flag", {31'd0, oOvf}, 32'd1);
        check("ovf_first", oData, 32'hAABBCCDD);
        idle("ovf_drain", 1, 1'b1);
        check("ovf_second", oData, 32'h01020304);
        idle("ovf_drain", 1, 1'b1);
        check("ovf_empty", {31'd0, oValid}, 32'd0);
        step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", {31'd0, oOvf}, 32'd0);

        // Transfer and completion on the same edge while one word is held.
        sendWord("same", 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
        sendWord("same", 32'h55AA33CC, 1'b0, 1'b1, 1'b0);
        check("same_word", oData, 32'h55AA33CC);
        check("same_valid", {31'd0, oValid}, 32'd1);
        idle("same_drain", 1, 1'b1);

        // Overflow set wins over a simultaneous clear.
        sendWord("setwin", 32'h11111111, 1'b0, 1'b0, 1'b0);
        sendWord("setwin", 32'h22222222, 1'b0, 1'b0, 1'b0);
        sendWord("setwin", 32'h33333333, 1'b0, 1'b0, 1'b1);
        check("setwin_ovf", {31'd0, oOvf}, 32'd1);
        step("setwin_clr", 1'b0, 8'h00, 1'b1, 1'b1);
        check("setwin_cleared", {31'd0, oOvf}, 32'd0);
        idle("setwin_drain", 2, 1'b1);

        // Reset mid-word discards the partial bytes.
        step("midrst", 1'b1, 8'h99, 1'b1, 1'b0);
        step("midrst", 1'b1, 8'h88, 1'b1, 1'b0);
        resetPulse("midrst_reset");
        sendWord("midrst", 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
        check("midrst_word", oData, 32'hDEADBEEF);
        idle("midrst_drain", 1, 1'b1);

`ifdef INBUF_TIMEOUT_EN
        // Idle gap equal to TIMEOUT discards the partial word.
        step("tmo", 1'b1, 8'h11, 1'b1, 1'b0);
        step("tmo", 1'b1, 8'h22, 1'b1, 1'b0);
        idle("tmo", 4, 1'b1);
        sendWord("tmo", 32'h33445566, 1'b1, 1'b0, 1'b0);
        check("tmo_flag", {31'd0, oTmo}, 32'd1);
        check("tmo_word", oData, 32'h33445566);
        step("tmo_clr", 1'b0, 8'h00, 1'b1, 1'b1);
        check("tmo_cleared", {31'd0, oTmo}, 32'd0);

        // Idle gap one short of TIMEOUT keeps the partial word.
        step("notmo", 1'b1, 8'h11, 1'b1, 1'b0);
        step("notmo", 1'b1, 8'h22, 1'b1, 1'b0);
        idle("notmo", 3, 1'b1);
        step("notmo", 1'b1, 8'h33, 1'b0, 1'b0);
        step("notmo", 1'b1, 8'h44, 1'b0, 1'b0);
        check("notmo_flag", {31'd0, oTmo}, 32'd0);
        check("notmo_word", oData, 32'h11223344);
        idle("notmo_drain", 1, 1'b1);
        resetPulse("notmo_reset");
`endif

        // Random traffic: dense bytes first, sparse bytes later to exercise idle gaps.
        for (int i = 0; i < 800; i++) begin
            bit         v, rdy, clr;
            logic [7:0] d;
            v   = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            d   = 8'($urandom);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 149) == 0) resetPulse("rand_reset");
            else step("rand", v, d, rdy, clr);
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
